sublvds_lane_merger: RTL and testbench

- Per-lane scheduler that sits after the per-lane word aligners of the Sony sub-LVDS receiver.
- Each lane delivers aligned, trailer-stripped words tagged with last and line_type. The block buffers them per lane.
- It sequences lanes round-robin (pixel k comes from lane k mod active_lanes) into one valid/ready pixel stream.
- It checks inter-lane consistency (line end, line type) and resynchronises all lanes on the next line after an error.

---
 rtl/sublvds_lane_merger.sv | 210 +++++++++++++++++++++
 tb/tb_sublvds_lane_merger.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sublvds_lane_merger.sv
// rtl/sublvds_lane_merger.sv - round-robin merger of aligned sub-LVDS lane words into one pixel stream
module sublvds_lane_merger #(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [12*NUM_LANES-1:0] lane_word_i,
    input  logic [NUM_LANES-1:0]    lane_valid_i,
    input  logic [NUM_LANES-1:0]    lane_last_i,
    input  logic [2*NUM_LANES-1:0]  lane_type_i,
    input  logic [1:0]              cfg_lanes_log2_i,
    input  logic                    err_clear_i,
    output logic [11:0]             pix_o,
    output logic                    pix_valid_o,
    input  logic                    pix_ready_i,
    output logic                    pix_last_o,
    output logic [1:0]              line_type_o,
    output logic [LINE_CNT_W-1:0]   line_count_o,
    output logic                    err_skew_o,
    output logic                    err_type_o,
    output logic                    err_ovf_o,
    output logic                    busy_o
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int IW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int NL_LOG2 = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // FIFO entry layout: {last, type[1:0], word[11:0]}
    logic [14:0]          mem_q    [NUM_LANES][FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q [NUM_LANES];
    logic [AW:0]          rd_ptr_q [NUM_LANES];
    logic [14:0]          head     [NUM_LANES];
    logic [NUM_LANES-1:0] empty, full, pop, push, clr, active;

    state_t                state_q;
    logic [IW-1:0]         idx_q, a_mask_q, new_mask;
    logic                  first_round_q, round_last_q;
    logic [NUM_LANES-1:0]  done_q, done_d;
    logic [11:0]           pix_q;
    logic                  pix_valid_q, pix_last_q;
    logic [1:0]            line_type_q;
    logic [LINE_CNT_W-1:0] line_count_q;
    logic                  err_skew_q, err_type_q, err_ovf_q;
    logic [1:0]            alog2;
    logic [3:0]            a_cnt;
    logic                  can_load, start, emit, skew_evt, type_evt, ovf_evt;
    logic                  flush_done, last_lane, rl_eff;
    logic [14:0]           cur;

    always_comb begin
        alog2    = (32'(cfg_lanes_log2_i) > NL_LOG2) ? 2'(NL_LOG2) : cfg_lanes_log2_i;
        a_cnt    = 4'd1 << alog2;
        new_mask = IW'(a_cnt - 4'd1);
        for (int n = 0; n < NUM_LANES; n++) begin
            empty[n]  = (wr_ptr_q[n] == rd_ptr_q[n]);
            full[n]   = (wr_ptr_q[n][AW] != rd_ptr_q[n][AW]) &&
                        (wr_ptr_q[n][AW-1:0] == rd_ptr_q[n][AW-1:0]);
            head[n]   = mem_q[n][rd_ptr_q[n][AW-1:0]];
            active[n] = (IW'(n) <= a_mask_q);
            clr[n]    = start && (IW'(n) > new_mask);
        end
        push    = lane_valid_i & (~full | pop);
        ovf_evt = |(lane_valid_i & full & ~pop);
    end

    always_comb begin
        cur       = head[idx_q];
        can_load  = !pix_valid_q || pix_ready_i;
        last_lane = (idx_q == a_mask_q);
        rl_eff    = (idx_q == '0) ? cur[14] : round_last_q;
        start     = 1'b0;
        emit      = 1'b0;
        skew_evt  = 1'b0;
        type_evt  = 1'b0;
        pop       = '0;
        done_d    = done_q;
        case (state_q)
            // A held word from the previous line keeps line_type_o until accepted
            IDLE: start = !empty[0] && can_load;
            RUN: begin
                if (!empty[idx_q]) begin
                    if (idx_q != '0 && cur[14] != round_last_q) begin
                        skew_evt = 1'b1;
                    end else if (idx_q != '0 && first_round_q && cur[13:12] != line_type_q) begin
                        type_evt = 1'b1;
                    end else if (can_load) begin
                        emit       = 1'b1;
                        pop[idx_q] = 1'b1;
                    end
                end
            end
            FLUSH: begin
                for (int n = 0; n < NUM_LANES; n++) begin
                    if (active[n] && !done_q[n] && !empty[n]) begin
                        pop[n]    = 1'b1;
                        done_d[n] = head[n][14];
                    end
                end
            end
            default: ;
        endcase
        flush_done = &(done_d | ~active);
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NUM_LANES; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n][AW-1:0]] <= {lane_last_i[n], lane_type_i[2*n +: 2], lane_word_i[12*n +: 12]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NUM_LANES; n++) begin
            if (reset_i || clr[n]) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end else begin
                if (push[n]) wr_ptr_q[n] <= wr_ptr_q[n] + 1'b1;
                if (pop[n])  rd_ptr_q[n] <= rd_ptr_q[n] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            a_mask_q      <= '0;
            first_round_q <= 1'b0;
            round_last_q  <= 1'b0;
            done_q        <= '0;
            pix_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_last_q    <= 1'b0;
            line_type_q   <= '0;
            line_count_q  <= '0;
            err_skew_q    <= 1'b0;
            err_type_q    <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            err_skew_q <= (err_skew_q && !err_clear_i) || skew_evt;
            err_type_q <= (err_type_q && !err_clear_i) || type_evt;
            err_ovf_q  <= (err_ovf_q && !err_clear_i) || ovf_evt;

            if (emit) begin
                pix_q       <= cur[11:0];
                pix_last_q  <= rl_eff && last_lane;
                pix_valid_q <= 1'b1;
            end else if (pix_ready_i) begin
                pix_valid_q <= 1'b0;
            end
            if (pix_valid_q && pix_ready_i && pix_last_q) begin
                line_count_q <= line_count_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_mask_q      <= new_mask;
                        line_type_q   <= head[0][13:12];
                        first_round_q <= 1'b1;
                        idx_q         <= '0;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    if (skew_evt || type_evt) begin
                        // Lanes already emitted this round consumed an entry whose last equals round_last
                        for (int n = 0; n < NUM_LANES; n++) begin
                            done_q[n] <= (IW'(n) < idx_q) && round_last_q;
                        end
                        state_q <= FLUSH;
                    end else if (emit) begin
                        if (idx_q == '0) round_last_q <= cur[14];
                        if (last_lane) begin
                            first_round_q <= 1'b0;
                            idx_q         <= '0;
                            if (rl_eff) state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    done_q <= done_d;
                    if (flush_done) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_o        = pix_q;
    assign pix_valid_o  = pix_valid_q;
    assign pix_last_o   = pix_last_q;
    assign line_type_o  = line_type_q;
    assign line_count_o = line_count_q;
    assign err_skew_o   = err_skew_q;
    assign err_type_o   = err_type_q;
    assign err_ovf_o    = err_ovf_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_sublvds_lane_merger.sv
// tb/tb_sublvds_lane_merger.sv - scoreboard bench for sublvds_lane_merger
module tb_sublvds_lane_merger;
    localparam int NL = 4;
    localparam int FD = 16;
    localparam int LW = 16;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [12*NL-1:0] lane_word_i;
    logic [NL-1:0]   lane_valid_i;
    logic [NL-1:0]   lane_last_i;
    logic [2*NL-1:0] lane_type_i;
    logic [1:0]      cfg_lanes_log2_i;
    logic            err_clear_i;
    logic [11:0]     pix_o;
    logic            pix_valid_o;
    logic            pix_ready_i;
    logic            pix_last_o;
    logic [1:0]      line_type_o;
    logic [LW-1:0]   line_count_o;
    logic            err_skew_o, err_type_o, err_ovf_o, busy_o;

    always #5 clk_i = ~clk_i;

    sublvds_lane_merger #(.NUM_LANES(NL), .FIFO_DEPTH(FD), .LINE_CNT_W(LW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .lane_word_i(lane_word_i), .lane_valid_i(lane_valid_i),
        .lane_last_i(lane_last_i), .lane_type_i(lane_type_i), .cfg_lanes_log2_i(cfg_lanes_log2_i),
        .err_clear_i(err_clear_i), .pix_o(pix_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
        .pix_last_o(pix_last_o), .line_type_o(line_type_o), .line_count_o(line_count_o),
        .err_skew_o(err_skew_o), .err_type_o(err_type_o), .err_ovf_o(err_ovf_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [11:0] w;
        logic        last;
        logic [1:0]  t;
    } ent_t;

    ent_t        mq   [NL][$];
    ent_t        stim [NL][$];
    logic [14:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_lines = 0;
    bit exp_skew = 0, exp_type = 0, exp_ovf = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic int lanes_of(input int cfg);
        int a;
        a = 1 << cfg;
        if (a > NL) a = NL;
        return a;
    endfunction

    // Expected pixel order: round k visits lanes 0..a-1; line ends when lane 0's word is last
    task automatic model_line(input int a);
        logic rl;
        logic [1:0] t0;
        int k, errl;
        bit fin;
        ent_t e;
        t0 = mq[0][0].t;
        k = 0;
        fin = 0;
        rl = 1'b0;
        while (!fin) begin
            errl = 0;
            for (int l = 0; l < a; l++) begin
                e = mq[l][0];
                if (l == 0) rl = e.last;
                else if (e.last != rl) begin exp_skew = 1; errl = l; break; end
                else if (k == 0 && e.t != t0) begin exp_type = 1; errl = l; break; end
                exp_q.push_back({e.w, rl && (l == a - 1), t0});
                void'(mq[l].pop_front());
            end
            if (errl != 0) begin
                for (int l = 0; l < a; l++) begin
                    if (!(l < errl && rl)) begin
                        e = mq[l].pop_front();
                        while (!e.last && mq[l].size() > 0) e = mq[l].pop_front();
                    end
                end
                fin = 1;
            end else if (rl) begin
                exp_lines++;
                fin = 1;
            end else begin
                k++;
            end
        end
    endtask

    task automatic make_line(input int a, input int len, input bit pattern, input logic [1:0] ty);
        ent_t e;
        for (int l = 0; l < NL; l++) stim[l].delete();
        for (int l = 0; l < a; l++) begin
            for (int k = 0; k < len; k++) begin
                e.w    = pattern ? 12'(256 * l + k) : 12'($urandom);
                e.last = (k == len - 1);
                e.t    = ty;
                stim[l].push_back(e);
            end
        end
    endtask

    task automatic load_model(input int cfg);
        cfg_lanes_log2_i = 2'(cfg);
        for (int l = 0; l < NL; l++) begin
            foreach (stim[l][i]) mq[l].push_back(stim[l][i]);
        end
        model_line(lanes_of(cfg));
    endtask

    task automatic drive(input bit gaps);
        int p[NL];
        bit more;
        for (int l = 0; l < NL; l++) p[l] = 0;
        more = 1;
        while (more) begin
            more = 0;
            for (int l = 0; l < NL; l++) begin
                if (p[l] < stim[l].size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                    lane_word_i[12*l +: 12] = stim[l][p[l]].w;
                    lane_last_i[l]          = stim[l][p[l]].last;
                    lane_type_i[2*l +: 2]   = stim[l][p[l]].t;
                    lane_valid_i[l]         = 1'b1;
                    p[l]++;
                end else begin
                    lane_valid_i[l] = 1'b0;
                end
            end
            tick();
            for (int l = 0; l < NL; l++) if (p[l] < stim[l].size()) more = 1;
        end
        lane_valid_i = '0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy_o || pix_valid_o) && c < 3000) begin
            tick();
            c++;
        end
        chk({name, "_drain"}, 32'(c < 3000), 32'd1);
        chk({name, "_lines"}, 32'(line_count_o), 32'(exp_lines));
        chk({name, "_errs"}, {29'd0, err_skew_o, err_type_o, err_ovf_o}, {29'd0, exp_skew, exp_type, exp_ovf});
    endtask

    task automatic clear_errs(input string name);
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        exp_skew = 0;
        exp_type = 0;
        exp_ovf  = 0;
        chk({name, "_cleared"}, {29'd0, err_skew_o, err_type_o, err_ovf_o}, 32'd0);
    endtask

    task automatic do_reset(input string name);
        reset_i = 1'b1;
        exp_q.delete();
        for (int l = 0; l < NL; l++) mq[l].delete();
        exp_lines = 0;
        exp_skew = 0;
        exp_type = 0;
        exp_ovf  = 0;
        tick();
        chk({name, "_pix"}, {17'd0, pix_valid_o, pix_o, pix_last_o, line_type_o}, 32'd0);
        chk({name, "_cnt"}, 32'(line_count_o), 32'd0);
        chk({name, "_err"}, {29'd0, err_skew_o, err_type_o, err_ovf_o}, 32'd0);
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        pix_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       pix_ready_i = 1'b1;
                1:       pix_ready_i = 1'($urandom_range(0, 1));
                default: pix_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        logic [14:0] prev, e;
        bit hold;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                hold = 0;
            end else begin
                if (hold) chk("stable", {16'd0, pix_valid_o, pix_o, pix_last_o, line_type_o}, {16'd0, 1'b1, prev});
                if (pix_valid_o && pix_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pix actual=%0h required=none", {pix_o, pix_last_o, line_type_o});
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix", 32'({pix_o, pix_last_o, line_type_o}), 32'(e));
                    end
                end
                hold = pix_valid_o && !pix_ready_i;
                prev = {pix_o, pix_last_o, line_type_o};
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cfg;
        ent_t e;
        reset_i = 1'b1;
        lane_word_i = '0;
        lane_valid_i = '0;
        lane_last_i = '0;
        lane_type_i = '0;
        cfg_lanes_log2_i = 2'd2;
        err_clear_i = 1'b0;
        tick(3);
        do_reset("reset");

        rdy_mode = 0;
        make_line(4, 8, 1, 2'd3);
        load_model(2);
        drive(0);
        wait_idle("basic");

        rdy_mode = 1;
        make_line(4, 8, 1, 2'd3);
        load_model(2);
        drive(1);
        wait_idle("stall");

        make_line(4, 8, 1, 2'd3);
        while (stim[2].size() > 6) void'(stim[2].pop_back());
        e = stim[2][5];
        e.last = 1'b1;
        stim[2][5] = e;
        load_model(2);
        drive(1);
        wait_idle("skew");
        make_line(4, $urandom_range(1, 8), 0, 2'($urandom_range(1, 3)));
        load_model(2);
        drive(1);
        wait_idle("skew_recover");
        clear_errs("skew");

        make_line(4, 8, 1, 2'd3);
        for (int i = 0; i < stim[3].size(); i++) begin
            e = stim[3][i];
            e.t = 2'd2;
            stim[3][i] = e;
        end
        load_model(2);
        drive(1);
        wait_idle("type");
        make_line(2, $urandom_range(1, 8), 0, 2'($urandom_range(1, 3)));
        load_model(1);
        drive(1);
        wait_idle("type_recover");
        clear_errs("type");

        for (int it = 0; it < 10; it++) begin
            cfg = $urandom_range(0, 3);
            rdy_mode = (it % 3 == 0) ? 0 : 1;
            make_line(lanes_of(cfg), $urandom_range(1, 8), 0, 2'($urandom_range(1, 3)));
            load_model(cfg);
            drive(it % 2 == 1);
            wait_idle("rand");
        end

        rdy_mode = 2;
        cfg_lanes_log2_i = 2'd1;
        tick(2);
        for (int i = 0; i < FD + 2; i++) begin
            lane_word_i[11:0] = 12'(i);
            lane_last_i[0] = 1'b0;
            lane_type_i[1:0] = 2'd3;
            lane_valid_i[0] = 1'b1;
            tick();
        end
        lane_valid_i = '0;
        lane_word_i[23:12] = 12'h0ab;
        lane_last_i[1] = 1'b1;
        lane_type_i[3:2] = 2'd3;
        lane_valid_i[1] = 1'b1;
        tick();
        lane_valid_i = '0;
        tick(5);
        chk("ovf_flag", 32'(err_ovf_o), 32'd1);
        chk("ovf_skew", 32'(err_skew_o), 32'd1);
        chk("ovf_busy", 32'(busy_o), 32'd1);
        clear_errs("ovf");
        chk("clear_keeps_state", 32'(busy_o), 32'd1);
        do_reset("ovf_reset");

        rdy_mode = 1;
        make_line(4, 8, 1, 2'd3);
        load_model(2);
        for (int l = 0; l < NL; l++) while (stim[l].size() > 4) void'(stim[l].pop_back());
        drive(1);
        tick(3);
        do_reset("mid_reset");
        make_line(4, 8, 0, 2'd2);
        load_model(2);
        drive(1);
        wait_idle("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
